// File: rtl/serial_frame_endpoint.sv
// Serial frame endpoint: TX FIFO + start/stop serialiser, RX deserialiser with SFD/stop checking,
// address filtering and a saturating error counter.
//
// TX FSM  state    | meaning
//         TX_IDLE  | line high, pop next frame when FIFO not empty
//         TX_START | drive start bit (low)
//         TX_DATA  | shift frame out MSB first, FW cycles
//         TX_STOP  | drive stop bits (high), STOP_BITS cycles
// RX FSM  state    | meaning
//         RX_IDLE  | wait for armed line falling to start bit
//         RX_DATA  | shift FW bits in, MSB first
//         RX_STOP  | sample stop bit, check SFD and DST
module serial_frame_endpoint #(
    parameter int SFD_WIDTH     = 4,
    parameter int ADDR_WIDTH    = 4,
    parameter int PAYLOAD_WIDTH = 4,
    parameter logic [SFD_WIDTH-1:0]  SFD_PATTERN = SFD_WIDTH'(4'b1010),
    parameter logic [ADDR_WIDTH-1:0] MAC_ADDRESS = '0,
    parameter int TX_FIFO_DEPTH = 4,
    parameter int STOP_BITS     = 1,
    localparam int FW = SFD_WIDTH + 2 * ADDR_WIDTH + PAYLOAD_WIDTH
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [FW-1:0] tx_frame,
    input  logic          tx_valid,
    output logic          tx_ready,
    output logic          tx_busy,
    output logic          tx_bit,
    input  logic          promisc,
    input  logic          rx_bit,
    output logic [FW-1:0] rx_frame,
    output logic          rx_valid,
    output logic          rx_err,
    output logic [7:0]    rx_err_cnt
);
    localparam int AW_F  = $clog2(TX_FIFO_DEPTH);
    localparam int TXC_W = $clog2(((FW > STOP_BITS) ? FW : STOP_BITS) + 1);
    localparam int RXC_W = $clog2(FW + 1);
    localparam logic [ADDR_WIDTH-1:0] BCAST = '1;

    localparam logic [1:0] TX_IDLE  = 2'd0;
    localparam logic [1:0] TX_START = 2'd1;
    localparam logic [1:0] TX_DATA  = 2'd2;
    localparam logic [1:0] TX_STOP  = 2'd3;

    localparam logic [1:0] RX_IDLE  = 2'd0;
    localparam logic [1:0] RX_DATA  = 2'd1;
    localparam logic [1:0] RX_STOP  = 2'd2;

    logic [FW-1:0]    fifo_mem [TX_FIFO_DEPTH];
    logic [AW_F-1:0]  wr_ptr;
    logic [AW_F-1:0]  rd_ptr;
    logic [AW_F:0]    fifo_count;
    logic             fifo_full;
    logic             fifo_empty;
    logic             tx_push;
    logic             tx_pop;

    logic [1:0]       tx_state;
    logic [TXC_W-1:0] tx_cnt;
    logic [FW-1:0]    tx_shift;

    logic             rx_m;
    logic             rx_s;
    logic             rx_armed;
    logic [1:0]       rx_state;
    logic [RXC_W-1:0] rx_cnt;
    logic [FW-1:0]    rx_shift;
    logic [SFD_WIDTH-1:0]  rx_sfd;
    logic [ADDR_WIDTH-1:0] rx_dst;
    logic             rx_addr_ok;

    assign fifo_full  = (fifo_count == (AW_F+1)'(TX_FIFO_DEPTH));
    assign fifo_empty = (fifo_count == '0);
    assign tx_ready   = !fifo_full;
    assign tx_push    = tx_valid && !fifo_full;
    assign tx_pop     = (tx_state == TX_IDLE) && !fifo_empty;
    assign tx_busy    = (tx_state != TX_IDLE);

    always_ff @(posedge clk) begin
        if (tx_push) begin
            fifo_mem[wr_ptr] <= tx_frame;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (tx_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (tx_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({tx_push, tx_pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // tx_bit is registered from the current state, so each state's level appears one edge later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state <= TX_IDLE;
            tx_bit   <= 1'b1;
            tx_cnt   <= '0;
            tx_shift <= '0;
        end else begin
            case (tx_state)
                TX_IDLE: begin
                    tx_bit <= 1'b1;
                    if (tx_pop) begin
                        tx_shift <= fifo_mem[rd_ptr];
                        tx_state <= TX_START;
                    end
                end
                TX_START: begin
                    tx_bit   <= 1'b0;
                    tx_cnt   <= TXC_W'(FW - 1);
                    tx_state <= TX_DATA;
                end
                TX_DATA: begin
                    tx_bit   <= tx_shift[FW-1];
                    tx_shift <= {tx_shift[FW-2:0], 1'b0};
                    if (tx_cnt == '0) begin
                        tx_cnt   <= TXC_W'(STOP_BITS - 1);
                        tx_state <= TX_STOP;
                    end else begin
                        tx_cnt <= tx_cnt - 1'b1;
                    end
                end
                TX_STOP: begin
                    tx_bit <= 1'b1;
                    if (tx_cnt == '0) begin
                        tx_state <= TX_IDLE;
                    end else begin
                        tx_cnt <= tx_cnt - 1'b1;
                    end
                end
                default: begin
                    tx_bit   <= 1'b1;
                    tx_state <= TX_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= rx_bit;
            rx_s <= rx_m;
        end
    end

    assign rx_sfd     = rx_shift[FW-1 -: SFD_WIDTH];
    assign rx_dst     = rx_shift[FW-SFD_WIDTH-1 -: ADDR_WIDTH];
    assign rx_addr_ok = promisc || (rx_dst == MAC_ADDRESS) || (rx_dst == BCAST) || (MAC_ADDRESS == BCAST);

    // An error disarms the receiver so a line stuck low cannot retrigger frames.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_state   <= RX_IDLE;
            rx_cnt     <= '0;
            rx_shift   <= '0;
            rx_frame   <= '0;
            rx_valid   <= 1'b0;
            rx_err     <= 1'b0;
            rx_err_cnt <= '0;
            rx_armed   <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            rx_err   <= 1'b0;
            if (rx_s) begin
                rx_armed <= 1'b1;
            end
            case (rx_state)
                RX_IDLE: begin
                    if (rx_armed && !rx_s) begin
                        rx_cnt   <= RXC_W'(FW);
                        rx_state <= RX_DATA;
                    end
                end
                RX_DATA: begin
                    rx_shift <= {rx_shift[FW-2:0], rx_s};
                    rx_cnt   <= rx_cnt - 1'b1;
                    if (rx_cnt == RXC_W'(1)) begin
                        rx_state <= RX_STOP;
                    end
                end
                RX_STOP: begin
                    rx_state <= RX_IDLE;
                    if (!rx_s || (rx_sfd != SFD_PATTERN)) begin
                        rx_err   <= 1'b1;
                        rx_armed <= 1'b0;
                        if (rx_err_cnt != 8'hFF) begin
                            rx_err_cnt <= rx_err_cnt + 8'd1;
                        end
                    end else if (rx_addr_ok) begin
                        rx_frame <= rx_shift;
                        rx_valid <= 1'b1;
                    end
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_frame_endpoint.sv
// Directed bench for serial_frame_endpoint: loopback latency, FIFO fill/order/gaps, address filter,
// error handling and saturation, and mid-frame reset.
module tb_serial_frame_endpoint;
    localparam int FW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [FW-1:0] tx_frame;
    logic          tx_valid;
    logic          tx_ready;
    logic          tx_busy;
    logic          tx_bit;
    logic          promisc;
    logic          rx_bit;
    logic [FW-1:0] rx_frame;
    logic          rx_valid;
    logic          rx_err;
    logic [7:0]    rx_err_cnt;

    logic loop;
    logic rx_drv;
    assign rx_bit = loop ? tx_bit : rx_drv;

    always #5 clk = ~clk;

    serial_frame_endpoint #(
        .SFD_WIDTH(4), .ADDR_WIDTH(4), .PAYLOAD_WIDTH(4),
        .SFD_PATTERN(4'b1010), .MAC_ADDRESS(4'h3),
        .TX_FIFO_DEPTH(4), .STOP_BITS(3)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .tx_frame(tx_frame), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .tx_busy(tx_busy), .tx_bit(tx_bit),
        .promisc(promisc), .rx_bit(rx_bit),
        .rx_frame(rx_frame), .rx_valid(rx_valid), .rx_err(rx_err), .rx_err_cnt(rx_err_cnt)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int n_valid  = 0;
    int n_err    = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rx_valid === 1'b1) n_valid++;
        if (rx_err === 1'b1) n_err++;
    end

    // Independent line decoder: frames and high-gap lengths between frames.
    logic          dec_en = 1'b0;
    logic          d_busy = 1'b0;
    logic          d_seen = 1'b0;
    int            d_run  = 0;
    int            d_n    = 0;
    logic [FW-1:0] d_sh   = '0;
    logic [FW-1:0] tx_q[$];
    int            gap_q[$];

    always @(negedge clk) begin
        if (!dec_en) begin
            d_busy = 1'b0;
            d_seen = 1'b0;
            d_run  = 0;
        end else if (!d_busy) begin
            if (tx_bit) begin
                d_run++;
            end else begin
                if (d_seen) gap_q.push_back(d_run);
                d_busy = 1'b1;
                d_n    = 0;
            end
        end else begin
            d_sh = {d_sh[FW-2:0], tx_bit};
            d_n++;
            if (d_n == FW) begin
                tx_q.push_back(d_sh);
                d_busy = 1'b0;
                d_seen = 1'b1;
                d_run  = 0;
            end
        end
    end

    task automatic send_rx(input logic [FW-1:0] f, input logic stop, input logic idle, input int idle_cycles);
        @(negedge clk) rx_drv = 1'b0;
        for (int i = FW - 1; i >= 0; i--) begin
            @(negedge clk) rx_drv = f[i];
        end
        @(negedge clk) rx_drv = stop;
        @(negedge clk) rx_drv = idle;
        repeat (idle_cycles) @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    logic [FW-1:0] t2_frames [5];
    int v0;
    int e0;

    initial begin
        loop     = 1'b1;
        rx_drv   = 1'b1;
        promisc  = 1'b0;
        tx_valid = 1'b0;
        tx_frame = '0;
        t2_frames[0] = 16'h1234;
        t2_frames[1] = 16'hA35C;
        t2_frames[2] = 16'hFFFF;
        t2_frames[3] = 16'h0000;
        t2_frames[4] = 16'h8001;

        repeat (3) @(negedge clk);
        chk("rst_tx_bit", tx_bit, 1);
        chk("rst_tx_ready", tx_ready, 1);
        chk("rst_tx_busy", tx_busy, 0);
        chk("rst_rx_frame", rx_frame, 0);
        chk("rst_rx_valid", rx_valid, 0);
        chk("rst_err_cnt", rx_err_cnt, 0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Loopback latency
        @(posedge clk); #1 tx_frame = 16'hA35C; tx_valid = 1'b1;
        @(posedge clk); #1 tx_valid = 1'b0;
        @(posedge clk); #1 chk("t1_e1_bit", tx_bit, 1);
        chk("t1_e1_busy", tx_busy, 1);
        @(posedge clk); #1 chk("t1_start_bit", tx_bit, 0);
        @(posedge clk); #1 chk("t1_msb", tx_bit, 1);
        for (int e = 4; e <= 21; e++) begin
            @(posedge clk); #1 chk("t1_no_early_valid", rx_valid, 0);
        end
        @(posedge clk); #1 chk("t1_valid", rx_valid, 1);
        chk("t1_frame", rx_frame, 16'hA35C);
        chk("t1_err", rx_err, 0);
        repeat (10) @(negedge clk);
        loop = 1'b0;

        // FIFO fill, order and inter-frame gaps
        dec_en = 1'b1;
        @(posedge clk); #1 tx_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tx_frame = t2_frames[i];
            @(posedge clk); #1;
            if (i == 3) chk("t2_ready_before_full", tx_ready, 1);
        end
        chk("t2_full", tx_ready, 0);
        tx_valid = 1'b0;
        for (int w = 0; w < 400 && tx_q.size() < 5; w++) @(negedge clk);
        chk("t2_nframes", tx_q.size(), 5);
        for (int i = 0; i < 5 && i < tx_q.size(); i++) chk("t2_order", tx_q[i], t2_frames[i]);
        chk("t2_ngaps", gap_q.size(), 4);
        for (int i = 0; i < gap_q.size(); i++) chk("t2_gap", gap_q[i], 4);
        chk("t2_ready_after", tx_ready, 1);
        dec_en = 1'b0;
        repeat (10) @(negedge clk);

        // Address filter
        v0 = n_valid;
        e0 = n_err;
        send_rx(16'hA95C, 1'b1, 1'b1, 4);
        chk("t3_drop_valid", n_valid - v0, 0);
        chk("t3_drop_err", n_err - e0, 0);
        promisc = 1'b1;
        send_rx(16'hA95C, 1'b1, 1'b1, 4);
        chk("t3_promisc_valid", n_valid - v0, 1);
        chk("t3_promisc_frame", rx_frame, 16'hA95C);
        promisc = 1'b0;
        send_rx(16'hAF5C, 1'b1, 1'b1, 4);
        chk("t3_bcast_valid", n_valid - v0, 2);
        chk("t3_bcast_frame", rx_frame, 16'hAF5C);

        // Errors and re-arming
        send_rx(16'h535C, 1'b1, 1'b1, 4);
        chk("t4_sfd_err", n_err - e0, 1);
        chk("t4_sfd_cnt", rx_err_cnt, 1);
        chk("t4_sfd_frame_held", rx_frame, 16'hAF5C);
        send_rx(16'hA35C, 1'b0, 1'b0, 40);
        chk("t4_stop_cnt", rx_err_cnt, 2);
        chk("t4_stop_err", n_err - e0, 2);
        chk("t4_stop_no_valid", n_valid - v0, 2);
        rx_drv = 1'b1;
        repeat (3) @(negedge clk);
        send_rx(16'hA35C, 1'b1, 1'b1, 4);
        chk("t4_rearm_valid", n_valid - v0, 3);
        chk("t4_rearm_frame", rx_frame, 16'hA35C);
        chk("t4_rearm_cnt", rx_err_cnt, 2);

        // Counter saturation
        e0 = n_err;
        repeat (300) send_rx(16'h535C, 1'b1, 1'b1, 2);
        repeat (2) @(negedge clk);
        chk("t5_sat_cnt", rx_err_cnt, 255);
        chk("t5_err_pulses", n_err - e0, 300);

        // Mid-frame reset
        loop = 1'b1;
        repeat (3) @(negedge clk);
        @(posedge clk); #1 tx_frame = 16'hA35C; tx_valid = 1'b1;
        @(posedge clk); #1 tx_frame = 16'hA36C;
        @(posedge clk); #1 tx_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1 rst_n = 1'b0;
        #1 chk("t6_tx_bit", tx_bit, 1);
        chk("t6_tx_ready", tx_ready, 1);
        chk("t6_tx_busy", tx_busy, 0);
        chk("t6_rx_valid", rx_valid, 0);
        chk("t6_err_cnt", rx_err_cnt, 0);
        chk("t6_rx_frame", rx_frame, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        v0 = n_valid;
        repeat (40) @(negedge clk);
        chk("t6_no_valid", n_valid - v0, 0);
        chk("t6_fifo_empty", tx_busy, 0);
        @(posedge clk); #1 tx_frame = 16'hA35C; tx_valid = 1'b1;
        @(posedge clk); #1 tx_valid = 1'b0;
        for (int w = 0; w < 40 && n_valid == v0; w++) @(negedge clk);
        @(negedge clk);
        chk("t6_next_valid", n_valid - v0, 1);
        chk("t6_next_frame", rx_frame, 16'hA35C);
        chk("t6_next_err_cnt", rx_err_cnt, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
